cont_gen: RTL and testbench
===========================

# cont_gen

Run-control input conditioner that sits directly upstream of the pipeline stop latch and drives its `continue` input. It synchronises and debounces the raw CONTINUE and STEP push-buttons and emits clean single-cycle `cont_pulse` events. In STEP mode it also issues a `halt_req` after a programmable number of run cycles, so the processor re-halts automatically. A 16-bit counter records how many resume events have been issued.

## Interface
- `DEB_CNT`, default 1_000_000: the number of consecutive stable cycles required to accept a key level change.
- `STEP_LEN`, default 5: the number of run cycles between a step's `cont_pulse` and its `halt_req`. Legal values are 1..255.
- `clk`, input, 1 bit: the single clock. All logic is clocked on the rising edge.
- `rst_n`, input, 1 bit: reset, asynchronous and active-low.
- `key_cont`, input, 1 bit: raw CONTINUE button, active-high, asynchronous to `clk`.
- `key_step`, input, 1 bit: raw STEP button, active-high, asynchronous to `clk`.
- `stop`, input, 1 bit: current halt state fed back from the stop latch. A value of 1 means halted.
- `cont_pulse`, output, 1 bit: a one-cycle resume strobe, wired to the stop latch `continue` input.
- `halt_req`, output, 1 bit: a one-cycle halt strobe, ORed into the halt-request path of the stop latch.
- `step_busy`, output, 1 bit: high while a step run is in progress.
- `resume_cnt`, output, 16 bits: the number of `cont_pulse` events issued since reset. It wraps from 0xFFFF to 0.

## Operation
- Reset values, applied asynchronously while `rst_n`=0:
  - `cont_pulse`=0, `halt_req`=0, `step_busy`=0, `resume_cnt`=0.
  - Synchronisers and debounced levels are 0, debounce counters are 0, and the FSM is in IDLE.
- Per key:
  - The key passes through a 2-flop synchroniser.
  - A debounce counter of width $clog2(DEB_CNT+1) resets whenever the synchronised level equals the debounced level or the synchronised level changes.
  - When the counter reaches DEB_CNT-1, the debounced level takes the synchronised value.
  - A rising edge of the debounced level produces a one-cycle internal `*_press` strobe.
- FSM states: IDLE, RUN_STEP, HALT.
  - In IDLE, `cont_press` with `stop`=1 asserts `cont_pulse` and increments `resume_cnt`. The FSM stays in IDLE.
  - In IDLE, `step_press` with `stop`=1 asserts `cont_pulse`, increments `resume_cnt`, loads the step counter with STEP_LEN-1 and goes to RUN_STEP.
  - In IDLE, a press while `stop`=0 is ignored, with no pulse and no count.
  - In RUN_STEP, `step_busy`=1. The step counter decrements once per cycle; at 0 the FSM goes to HALT.
  - In HALT, `halt_req`=1 for exactly one cycle, then the FSM returns to IDLE.
- Presses during RUN_STEP or HALT are ignored entirely.
- Simultaneous `cont_press` and `step_press` in IDLE: CONTINUE wins, no step is started, and exactly one `cont_pulse` is issued.
- If `stop` rises during RUN_STEP (for example from a syscall halt), the step still completes and `halt_req` is still issued. It is harmless because the processor is already halted.
- A key held down produces exactly one press. The next press requires a debounced release first.

## Timing
- Raw key edge to `cont_pulse`: 2 synchroniser cycles + DEB_CNT cycles + 1 registered cycle. All outputs are registered.
- A step's `cont_pulse` is on cycle T. `step_busy` is high on cycles T+1..T+STEP_LEN. `halt_req` is high on cycle T+STEP_LEN+1.
- `resume_cnt` updates on the same cycle that `cont_pulse` is high.
- A glitch shorter than DEB_CNT cycles never changes the debounced level.

## Structure
- Shared package `run_ctrl_pkg` holds:
  - the FSM state encoding (`ST_IDLE`=2'd0, `ST_RUN_STEP`=2'd1, `ST_HALT`=2'd2);
  - the default DEB_CNT and STEP_LEN constants.
- One sub-module, `key_debounce`, contains the synchroniser, the debounce counter and the rising-edge strobe. It takes a `DEB_CNT` parameter and is instantiated twice.

## Test plan
Benches run with DEB_CNT=4 and STEP_LEN=3.
- **Reset:** assert `rst_n`=0 mid-step run, during RUN_STEP → all outputs go to 0 immediately, and the FSM is in IDLE after release.
- **Continue:** `stop`=1, hold `key_cont` high for 10 cycles → exactly one `cont_pulse`, 7 cycles after the edge, and `resume_cnt`=1.
- **Bounce:** toggle `key_cont` high for 3 cycles and low for 2 cycles, repeated 5 times → no `cont_pulse` and `resume_cnt` unchanged.
- **Step:** `stop`=1, press `key_step` → `cont_pulse` at T, `step_busy` on T+1..T+3, `halt_req` at T+4, `resume_cnt` +1.
- **Both keys:** `stop`=1, `key_cont` and `key_step` rise on the same cycle → one `cont_pulse`, `step_busy` stays 0, no `halt_req`.
- **Running / wrap:** a press with `stop`=0 gives no pulse. Force `resume_cnt`=0xFFFF, then issue a continue → `resume_cnt`=0.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// Purpose: shared constants for the run-control conditioner (FSM encoding, defaults).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package run_ctrl_pkg;

  // Run-control FSM state encoding
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RUN_STEP = 2'd1;
  localparam logic [1:0] ST_HALT     = 2'd2;

  // Default debounce window (cycles) and step run length (cycles)
  localparam int DEB_CNT_DEF  = 1_000_000;
  localparam int STEP_LEN_DEF = 5;

endpackage

// File: rtl/key_debounce.sv
// Purpose: 2-flop synchroniser + debounce counter + rising-edge press strobe for one key.
// Latency: raw edge to press = 2 sync cycles + DEB_CNT cycles.
// Backpressure: none; a held key yields one press, the next needs a debounced release.
module key_debounce
  import run_ctrl_pkg::*;
#(
  parameter int DEB_CNT = DEB_CNT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic press
);

  localparam int CW = $clog2(DEB_CNT + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  // Bring the asynchronous key into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has been stable for DEB_CNT cycles;
  // sync1 != sync2 means the synchronised level is about to change, so restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if ((sync2 == level) || (sync1 != sync2)) begin
      cnt <= '0;
    end else if (cnt == CW'(DEB_CNT - 1)) begin
      cnt   <= '0;
      level <= sync2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Delayed copy of the debounced level for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d <= 1'b0;
    end else begin
      level_d <= level;
    end
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/cont_gen.sv
// Purpose: conditions CONTINUE/STEP keys into cont_pulse/halt_req strobes for the stop latch.
// Latency: key edge to cont_pulse = 2 + DEB_CNT + 1 cycles; halt_req STEP_LEN+1 cycles after a step pulse.
// Backpressure: none; presses while running or during a step run are dropped.
module cont_gen
  import run_ctrl_pkg::*;
#(
  parameter int DEB_CNT  = DEB_CNT_DEF,
  parameter int STEP_LEN = STEP_LEN_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_cont,
  input  logic        key_step,
  input  logic        stop,
  output logic        cont_pulse,
  output logic        halt_req,
  output logic        step_busy,
  output logic [15:0] resume_cnt
);

  logic       cont_press;
  logic       step_press;
  logic [1:0] state;
  logic [7:0] step_cnt;

  key_debounce #(.DEB_CNT(DEB_CNT)) u_deb_cont (
    .clk   (clk),
    .rst_n (rst_n),
    .key   (key_cont),
    .press (cont_press)
  );

  key_debounce #(.DEB_CNT(DEB_CNT)) u_deb_step (
    .clk   (clk),
    .rst_n (rst_n),
    .key   (key_step),
    .press (step_press)
  );

  // Run-control FSM: resume on a press while halted, time a step run, then re-halt.
  // CONTINUE wins over STEP when both presses land on the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      step_cnt   <= '0;
      cont_pulse <= 1'b0;
      resume_cnt <= '0;
    end else begin
      cont_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (stop && (cont_press || step_press)) begin
            cont_pulse <= 1'b1;
            resume_cnt <= resume_cnt + 16'd1;
            if (!cont_press) begin
              step_cnt <= 8'(STEP_LEN - 1);
              state    <= ST_RUN_STEP;
            end
          end
        end
        ST_RUN_STEP: begin
          if (step_cnt == 8'd0) begin
            state <= ST_HALT;
          end else begin
            step_cnt <= step_cnt - 8'd1;
          end
        end
        ST_HALT: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Registered status strobes, one cycle behind the state they report
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_busy <= 1'b0;
      halt_req  <= 1'b0;
    end else begin
      step_busy <= (state == ST_RUN_STEP);
      halt_req  <= (state == ST_HALT);
    end
  end

endmodule

// File: tb/tb_cont_gen.sv
// Purpose: self-checking bench for cont_gen against a window-based behavioural model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_cont_gen;
  import run_ctrl_pkg::*;

  localparam int DEB = 4;
  localparam int SL  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_cont = 1'b0;
  logic        key_step = 1'b0;
  logic        stop = 1'b0;
  logic        cont_pulse;
  logic        halt_req;
  logic        step_busy;
  logic [15:0] resume_cnt;

  always #5 clk = ~clk;

  cont_gen #(.DEB_CNT(DEB), .STEP_LEN(SL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_cont   (key_cont),
    .key_step   (key_step),
    .stop       (stop),
    .cont_pulse (cont_pulse),
    .halt_req   (halt_req),
    .step_busy  (step_busy),
    .resume_cnt (resume_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: a key's debounced level takes value v once the last
  // DEB+1 raw samples (excluding the current edge) all equal v.
  int          cyc;
  int          t_step;
  logic [DEB:0] hc, hs;
  logic        deb_c, deb_s, pend_c, pend_s;
  logic [15:0] m_cnt;
  logic        e_pulse, e_busy, e_halt;

  // Observed-event trackers for directed checks
  int n_pulse, pulse_c, n_busy, busy_first, n_halt, halt_c;

  task automatic model_reset();
    t_step = -100;
    hc = '0; hs = '0;
    deb_c = 1'b0; deb_s = 1'b0; pend_c = 1'b0; pend_s = 1'b0;
    m_cnt = '0;
    e_pulse = 1'b0; e_busy = 1'b0; e_halt = 1'b0;
  endtask

  task automatic clear_obs();
    n_pulse = 0; pulse_c = -1; n_busy = 0; busy_first = -1; n_halt = 0; halt_c = -1;
  endtask

  task automatic tick();
    logic cp, sp, idle;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      model_reset();
    end else begin
      cp = pend_c;
      sp = pend_s;
      e_pulse = 1'b0;
      e_busy  = (t_step >= 0) && (cyc >= t_step + 1) && (cyc <= t_step + SL);
      e_halt  = (t_step >= 0) && (cyc == t_step + SL + 1);
      idle    = (t_step < 0) || (cyc >= t_step + SL + 2);
      if (idle && stop && (cp || sp)) begin
        e_pulse = 1'b1;
        m_cnt   = m_cnt + 16'd1;
        if (!cp) t_step = cyc;
      end
      pend_c = 1'b0;
      if (hc == {(DEB+1){~deb_c}}) begin
        deb_c  = ~deb_c;
        pend_c = deb_c;
      end
      pend_s = 1'b0;
      if (hs == {(DEB+1){~deb_s}}) begin
        deb_s  = ~deb_s;
        pend_s = deb_s;
      end
      hc = {hc[DEB-1:0], key_cont};
      hs = {hs[DEB-1:0], key_step};
    end
    @(negedge clk);
    check("cont_pulse", {31'd0, cont_pulse}, {31'd0, e_pulse});
    check("step_busy",  {31'd0, step_busy},  {31'd0, e_busy});
    check("halt_req",   {31'd0, halt_req},   {31'd0, e_halt});
    check("resume_cnt", {16'd0, resume_cnt}, {16'd0, m_cnt});
    if (cont_pulse) begin n_pulse++; pulse_c = cyc; end
    if (step_busy) begin
      if (n_busy == 0) busy_first = cyc;
      n_busy++;
    end
    if (halt_req) begin n_halt++; halt_c = cyc; end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int          c0;
  logic [15:0] snap;
  int          guard;
  int          seg;

  initial begin
    cyc = 0;
    model_reset();
    clear_obs();

    // Reset state
    run(3);
    check("reset_pulse", {31'd0, cont_pulse}, 32'd0);
    check("reset_cnt",   {16'd0, resume_cnt}, 32'd0);
    rst_n = 1'b1;
    run(4);

    // Continue: one pulse, 7 cycles after the key edge
    stop = 1'b1;
    clear_obs();
    snap = m_cnt;
    c0 = cyc;
    key_cont = 1'b1;
    run(10);
    key_cont = 1'b0;
    run(12);
    check("cont_npulse", n_pulse, 1);
    check("cont_latency", pulse_c - c0, 7);
    check("cont_count", {16'd0, resume_cnt}, {16'd0, snap + 16'd1});

    // Bounce: short highs never get through
    clear_obs();
    snap = m_cnt;
    for (int i = 0; i < 5; i++) begin
      key_cont = 1'b1; run(3);
      key_cont = 1'b0; run(2);
    end
    run(12);
    check("bounce_npulse", n_pulse, 0);
    check("bounce_count", {16'd0, resume_cnt}, {16'd0, snap});

    // Step: pulse at T, busy T+1..T+3, halt at T+4
    clear_obs();
    snap = m_cnt;
    key_step = 1'b1;
    run(8);
    key_step = 1'b0;
    run(12);
    check("step_npulse", n_pulse, 1);
    check("step_nbusy", n_busy, SL);
    check("step_busy_start", busy_first - pulse_c, 1);
    check("step_nhalt", n_halt, 1);
    check("step_halt_at", halt_c - pulse_c, SL + 1);
    check("step_count", {16'd0, resume_cnt}, {16'd0, snap + 16'd1});

    // Both keys on the same cycle: CONTINUE wins
    clear_obs();
    key_cont = 1'b1; key_step = 1'b1;
    run(8);
    key_cont = 1'b0; key_step = 1'b0;
    run(12);
    check("both_npulse", n_pulse, 1);
    check("both_nbusy", n_busy, 0);
    check("both_nhalt", n_halt, 0);

    // Running: press with stop=0 is ignored
    stop = 1'b0;
    clear_obs();
    key_cont = 1'b1; run(10);
    key_cont = 1'b0; run(12);
    check("run_npulse", n_pulse, 0);

    // Wrap of resume_cnt
    stop = 1'b1;
    force dut.resume_cnt = 16'hFFFF;
    m_cnt = 16'hFFFF;
    run(1);
    release dut.resume_cnt;
    run(1);
    key_cont = 1'b1; run(10);
    key_cont = 1'b0; run(12);
    check("wrap_count", {16'd0, resume_cnt}, 32'd0);

    // Reset in the middle of a step run
    clear_obs();
    key_step = 1'b1;
    guard = 0;
    while (n_busy == 0 && guard < 40) begin
      tick();
      guard++;
    end
    check("rst_step_started", {31'd0, (n_busy > 0)}, 32'd1);
    key_step = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_busy",  {31'd0, step_busy},  32'd0);
    check("rst_async_pulse", {31'd0, cont_pulse}, 32'd0);
    check("rst_async_halt",  {31'd0, halt_req},   32'd0);
    check("rst_async_cnt",   {16'd0, resume_cnt}, 32'd0);
    run(3);
    rst_n = 1'b1;
    check("rst_idle", {30'd0, dut.state}, {30'd0, ST_IDLE});
    run(12);

    // Randomized segments checked every cycle against the model
    for (seg = 0; seg < 120; seg++) begin
      key_cont = ($urandom_range(0, 3) == 0);
      key_step = ($urandom_range(0, 2) == 0);
      stop     = ($urandom_range(0, 3) != 0);
      run($urandom_range(1, 12));
    end
    key_cont = 1'b0; key_step = 1'b0;
    run(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
